ram_loader: RTL

- Write-side front end for the pixel/weight storage RAM.
- Accepts a SIZE_1-wide signed value stream over a valid/ready handshake.
- In picture mode, each value becomes one pixel word written on the pixel write port.
- In weight mode, every 9 consecutive values are packed into one SIZE_9 kernel word written on the weight write port.
- Sits between the host/ROM stream source and the RAM write ports. The controller launches it with a start pulse and waits for done.

---
 rtl/ram_loader.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ram_loader.sv
// ram_loader: write-side front end for the pixel/weight storage RAM.
// Consumes a SIZE_1-wide value stream over valid/ready. In picture mode each
// value becomes one pixel write. In weight mode nine values are packed,
// first value most significant, into one SIZE_9 kernel word.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start, mode          launch pulse (IDLE only); 0 = picture, 1 = weights
//   base_p, n_words      first pixel address / weight word count, taken at start
//   in_data, in_valid    stream beat; in_ready = loader accepts this cycle
//   dp, write_addressp, we_p   pixel write port
//   dw, write_addressw, we_w   weight write port
//   busy, done           load in progress / one-cycle completion pulse
module ram_loader #(
  parameter int unsigned picture_size     = 28,
  parameter int unsigned SIZE_1           = 12,
  parameter int unsigned SIZE_9           = 108,
  parameter int unsigned SIZE_address_pix = 13,
  parameter int unsigned SIZE_address_wei = 9
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          mode,
  input  logic [SIZE_address_pix-1:0]   base_p,
  input  logic [SIZE_address_wei-1:0]   n_words,
  input  logic signed [SIZE_1-1:0]      in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [SIZE_1-1:0]             dp,
  output logic [SIZE_address_pix-1:0]   write_addressp,
  output logic                          we_p,
  output logic [SIZE_9-1:0]             dw,
  output logic [SIZE_address_wei-1:0]   write_addressw,
  output logic                          we_w,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned PIX_WORDS = picture_size * picture_size;
  localparam int unsigned BEAT_W    = (PIX_WORDS > 1) ? $clog2(PIX_WORDS) : 1;
  localparam int unsigned SLOT_W    = 4;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] LOAD_PIX = 2'd1;
  localparam logic [1:0] LOAD_WEI = 2'd2;
  localparam logic [1:0] FIN      = 2'd3;

  logic [1:0]                  state, state_next;
  logic [BEAT_W-1:0]           beat_cnt, beat_next;
  logic [SLOT_W-1:0]           slot, slot_next;
  logic [SIZE_9-1:0]           pack, pack_next;
  logic [SIZE_address_pix-1:0] pix_addr, pix_addr_next;
  logic [SIZE_address_wei-1:0] word_cnt, word_next;
  logic [SIZE_address_wei-1:0] n_words_q, n_words_next;

  logic                        in_ready_next, we_p_next, we_w_next, busy_next, done_next;
  logic [SIZE_1-1:0]           dp_next;
  logic [SIZE_9-1:0]           dw_next;
  logic [SIZE_address_pix-1:0] addrp_next;
  logic [SIZE_address_wei-1:0] addrw_next;
  logic                        accept;

  // Next-state and next-output logic; every registered output is derived here.
  always_comb begin
    state_next    = state;
    beat_next     = beat_cnt;
    slot_next     = slot;
    pack_next     = pack;
    pix_addr_next = pix_addr;
    word_next     = word_cnt;
    n_words_next  = n_words_q;
    dp_next       = dp;
    dw_next       = dw;
    addrp_next    = write_addressp;
    addrw_next    = write_addressw;
    we_p_next     = 1'b0;
    we_w_next     = 1'b0;
    accept        = in_valid & in_ready;

    case (state)
      IDLE: begin
        if (start) begin
          if (!mode) begin
            state_next    = LOAD_PIX;
            pix_addr_next = base_p;
            beat_next     = '0;
          end else if (n_words != '0) begin
            state_next   = LOAD_WEI;
            word_next    = '0;
            beat_next    = '0;
            slot_next    = '0;
            pack_next    = '0;
            n_words_next = n_words;
          end else begin
            state_next = FIN;
          end
        end
      end
      LOAD_PIX: begin
        if (accept) begin
          we_p_next     = 1'b1;
          dp_next       = in_data;
          addrp_next    = pix_addr;
          pix_addr_next = SIZE_address_pix'(pix_addr + 1'b1);
          beat_next     = BEAT_W'(beat_cnt + 1'b1);
          if (beat_cnt == BEAT_W'(PIX_WORDS - 1)) state_next = FIN;
        end
      end
      LOAD_WEI: begin
        if (accept) begin
          // Shift left so the first beat ends up in the top slot.
          pack_next = {pack[SIZE_9-SIZE_1-1:0], in_data};
          if (slot == SLOT_W'(8)) begin
            we_w_next  = 1'b1;
            dw_next    = pack_next;
            addrw_next = word_cnt;
            word_next  = SIZE_address_wei'(word_cnt + 1'b1);
            slot_next  = '0;
            if (word_cnt == SIZE_address_wei'(n_words_q - 1'b1)) state_next = FIN;
          end else begin
            slot_next = SLOT_W'(slot + 1'b1);
          end
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Status flags follow the state being entered so they are registered with it.
    in_ready_next = (state_next == LOAD_PIX) || (state_next == LOAD_WEI);
    busy_next     = (state_next != IDLE);
    done_next     = (state_next == FIN);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      beat_cnt       <= '0;
      slot           <= '0;
      pack           <= '0;
      pix_addr       <= '0;
      word_cnt       <= '0;
      n_words_q      <= '0;
      in_ready       <= 1'b0;
      dp             <= '0;
      write_addressp <= '0;
      we_p           <= 1'b0;
      dw             <= '0;
      write_addressw <= '0;
      we_w           <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= state_next;
      beat_cnt       <= beat_next;
      slot           <= slot_next;
      pack           <= pack_next;
      pix_addr       <= pix_addr_next;
      word_cnt       <= word_next;
      n_words_q      <= n_words_next;
      in_ready       <= in_ready_next;
      dp             <= dp_next;
      write_addressp <= addrp_next;
      we_p           <= we_p_next;
      dw             <= dw_next;
      write_addressw <= addrw_next;
      we_w           <= we_w_next;
      busy           <= busy_next;
      done           <= done_next;
    end
  end

endmodule
